// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over several cycles,
// drives the shared-ALU datapath enables and issues the 3-bit ALUCtrl code.
`timescale 1ns/1ps
module mips_multicycle_ctrl #(
  parameter bit          USE_MEM_READY = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Z,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUCtrl,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_t;

  localparam state_t S_JUMP = state_t'(4'd11);

  state_t state_q;
  state_t state_d;
  logic   mem_rdy;
  logic   funct_ok;
  logic   pc_write;
  logic   branch;
  logic   retire;
  logic   illegal_d;

  always_comb mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

  // R-type functions this controller can execute
  always_comb begin
    funct_ok = 1'b0;
    case (Funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      illegal_op    <= 1'b0;
      instr_retired <= '0;
    end else begin
      state_q    <= state_d;
      illegal_op <= illegal_d;
      if (retire) begin
        instr_retired <= instr_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_B;
    ALUCtrl   = ALU_ADD;
    PCSrc     = PC_ALURES;
    pc_write  = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_rdy) begin
          IRWrite  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      // Speculatively form the branch target while the opcode is decoded
      S_DECODE: begin
        ALUSrcB = SRCB_IMM2;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXEC;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_rdy) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      // Write strobe stays asserted for the whole memory wait
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        case (Funct)
          FN_SUB:  ALUCtrl = ALU_SUB;
          FN_AND:  ALUCtrl = ALU_AND;
          FN_OR:   ALUCtrl = ALU_OR;
          FN_SLT:  ALUCtrl = ALU_SLT;
          default: ALUCtrl = ALU_ADD;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUCtrl = ALU_SUB;
        PCSrc   = PC_ALUOUT;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc    = PC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    PCEn = pc_write | (branch & Z);

    // Abandon any in-flight access while reset is held
    if (!rst_n) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      PCEn     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a transaction model expands each instruction into
// per-cycle stimulus plus expected controls, checked on the falling edge.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic        rst_n;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [16:0] exp;
    logic [3:0]  cnt;
  } cyc_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Z;
  logic       mem_ready;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUCtrl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal_op;
  logic [3:0] instr_retired;

  mips_multicycle_ctrl #(.USE_MEM_READY(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Z(Z), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl), .PCSrc(PCSrc), .PCEn(PCEn),
    .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t script[$];
  cyc_t cur;
  int   checks;
  int   failures;
  int   cyc;
  bit   built;
  bit   active;
  bit   finish_req;

  // model state
  logic       w_iord, w_memread, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite, w_alusrca, w_pcen;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluctrl;
  logic [5:0] i_op, i_fn;
  logic       i_z, i_rst, pend_ill;
  logic [3:0] mcount;

  int len_slt, len_lw, len_beqt, len_beqn, len_j, len_ill;
  int idx_slt_exec, idx_lw_wb;

  task automatic clr();
    w_iord = 0; w_memread = 0; w_memwrite = 0; w_irwrite = 0; w_regdst = 0;
    w_memtoreg = 0; w_regwrite = 0; w_alusrca = 0; w_pcen = 0;
    w_alusrcb = 2'b00; w_pcsrc = 2'b00; w_aluctrl = 3'b010;
  endtask

  task automatic emit(input logic mr, input logic retire, input logic ill_next);
    cyc_t c;
    c.rst_n = i_rst; c.mr = mr; c.z = i_z; c.op = i_op; c.funct = i_fn;
    c.exp = {w_iord, w_memread, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite,
             w_alusrca, w_alusrcb, w_aluctrl, w_pcsrc, w_pcen, pend_ill};
    c.cnt = mcount;
    script.push_back(c);
    pend_ill = ill_next;
    if (retire) mcount = mcount + 4'd1;
  endtask

  // {legal, alu code} for an R-type function field
  function automatic logic [3:0] rfn(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101010: return {1'b1, 3'b111};
      default:   return 4'b0000;
    endcase
  endfunction

  task automatic do_fetch(input int fst);
    for (int k = 0; k <= fst; k++) begin
      clr(); w_memread = 1; w_alusrcb = 2'b01;
      if (k == fst) begin w_irwrite = 1; w_pcen = 1; end
      emit(k == fst, 0, 0);
    end
  endtask

  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fst, input int mst);
    logic [3:0] r;
    logic       ok;
    i_op = op; i_fn = fn; i_z = z; i_rst = 1'b1;
    r = rfn(fn);
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      OP_R:    ok = r[3];
      default: ok = 1'b0;
    endcase
    do_fetch(fst);
    clr(); w_alusrcb = 2'b11; emit(0, 0, !ok);
    if (!ok) return;
    case (op)
      OP_LW, OP_SW: begin
        clr(); w_alusrca = 1; w_alusrcb = 2'b10; emit(0, 0, 0);
        for (int k = 0; k <= mst; k++) begin
          clr(); w_iord = 1;
          if (op == OP_LW) w_memread = 1; else w_memwrite = 1;
          emit(k == mst, (op == OP_SW) && (k == mst), 0);
        end
        if (op == OP_LW) begin
          clr(); w_memtoreg = 1; w_regwrite = 1; emit(0, 1, 0);
        end
      end
      OP_R: begin
        clr(); w_alusrca = 1; w_aluctrl = r[2:0]; emit(0, 0, 0);
        clr(); w_regdst = 1; w_regwrite = 1; emit(0, 1, 0);
      end
      OP_BEQ: begin
        clr(); w_alusrca = 1; w_aluctrl = 3'b110; w_pcsrc = 2'b01; w_pcen = z; emit(0, 1, 0);
      end
      OP_ADDI: begin
        clr(); w_alusrca = 1; w_alusrcb = 2'b10; emit(0, 0, 0);
        clr(); w_regwrite = 1; emit(0, 1, 0);
      end
      default: begin
        clr(); w_pcsrc = 2'b10; w_pcen = 1; emit(0, 1, 0);
      end
    endcase
  endtask

  // sw that stalls in the write state and is killed by reset mid-access
  task automatic add_sw_reset();
    i_op = OP_SW; i_fn = 6'b000000; i_z = 1'b0; i_rst = 1'b1;
    do_fetch(0);
    clr(); w_alusrcb = 2'b11; emit(0, 0, 0);
    clr(); w_alusrca = 1; w_alusrcb = 2'b10; emit(0, 0, 0);
    clr(); w_iord = 1; w_memwrite = 1; emit(0, 0, 0);
    i_rst = 1'b0;
    clr(); w_iord = 1; emit(0, 0, 0);
    i_rst = 1'b1; mcount = 4'd0; pend_ill = 1'b0;
  endtask

  task automatic add_idle(input int n);
    i_op = 6'b000000; i_fn = 6'b000000; i_z = 1'b0; i_rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      clr(); w_memread = 1; w_alusrcb = 2'b01; emit(0, 0, 0);
    end
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // driver
  initial begin
    int s;
    checks = 0; failures = 0; cyc = 0; active = 0; finish_req = 0; built = 0;
    mcount = 4'd0; pend_ill = 1'b0;
    s = script.size(); add_instr(OP_R, 6'b101010, 1'b0, 0, 0);
    len_slt = script.size() - s; idx_slt_exec = s + 2;
    s = script.size(); add_instr(OP_LW, 6'b101010, 1'b1, 2, 3);
    len_lw = script.size() - s; idx_lw_wb = script.size() - 1;
    s = script.size(); add_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0); len_beqt = script.size() - s;
    s = script.size(); add_instr(OP_BEQ, 6'b000000, 1'b0, 0, 0); len_beqn = script.size() - s;
    s = script.size(); add_instr(6'b111111, 6'b100000, 1'b0, 0, 0); len_ill = script.size() - s;
    add_instr(OP_R, 6'b000000, 1'b1, 0, 0);
    add_instr(OP_SW, 6'b000000, 1'b0, 1, 2);
    add_instr(OP_R, 6'b100000, 1'b0, 0, 0);
    add_instr(OP_R, 6'b100010, 1'b1, 1, 0);
    add_instr(OP_R, 6'b100100, 1'b0, 0, 0);
    add_instr(OP_R, 6'b100101, 1'b0, 0, 0);
    s = script.size(); add_instr(OP_J, 6'b000000, 1'b1, 0, 0); len_j = script.size() - s;
    add_sw_reset();
    for (int k = 0; k < 17; k++) add_instr(OP_ADDI, 6'b000000, k[0], 0, 0);
    add_idle(2);
    built = 1;

    rst_n = 1'b0; mem_ready = 1'b0; Z = 1'b0; Op = 6'b0; Funct = 6'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < script.size(); i++) begin
      @(posedge clk); #1;
      cur = script[i];
      cyc = i;
      rst_n = cur.rst_n; mem_ready = cur.mr; Z = cur.z; Op = cur.op; Funct = cur.funct;
      active = 1;
    end
    @(posedge clk); #1;
    active = 0;
    finish_req = 1;
  end

  // compare process
  initial begin : compare
    logic [16:0] got;
    cyc_t        e;
    int          ill_seen;
    ill_seen = 0;
    wait (built);
    check_lit("len_rtype", len_slt, 4);
    check_lit("len_lw_stalled", len_lw, 10);
    check_lit("len_beq_taken", len_beqt, 3);
    check_lit("len_beq_not_taken", len_beqn, 3);
    check_lit("len_j", len_j, 3);
    check_lit("len_illegal", len_ill, 2);
    e = script[idx_slt_exec];
    check_lit("model_slt_aluctrl", int'(e.exp[6:4]), 7);
    e = script[idx_lw_wb];
    check_lit("model_lw_memtoreg", int'(e.exp[11]), 1);
    check_lit("model_final_count", int'(mcount), 1);
    forever begin
      @(negedge clk);
      if (finish_req) break;
      if (active) begin
        got = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUCtrl, PCSrc, PCEn, illegal_op};
        checks++;
        if (got !== cur.exp || instr_retired !== cur.cnt) begin
          failures++;
          $display("FAIL ctl cycle=%0d op=%b fn=%b got=%b exp=%b retired got=%0d exp=%0d",
                   cyc, cur.op, cur.funct, got, cur.exp, instr_retired, cur.cnt);
        end
        checks++;
        if (!(ALUCtrl inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111})) begin
          failures++;
          $display("FAIL aluctrl_code cycle=%0d got=%b exp one of 000/001/010/110/111", cyc, ALUCtrl);
        end
        if (illegal_op === 1'b1) ill_seen++;
      end
    end
    check_lit("final_retired", int'(instr_retired), 1);
    check_lit("illegal_pulses", ill_seen, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
